// File: rtl/roce_stack_pkg.sv
// Shared types for the RoCE request handler: translation response, datamover command, error codes.
package roce_stack_pkg;

  localparam int unsigned PADDR_W = 64;
  localparam int unsigned BUFLEN_W = 32;
  localparam int unsigned RKEY_W = 24;
  localparam int unsigned BTT_W = 23;

  localparam logic [1:0] ACC_RD = 2'd0;
  localparam logic [1:0] ACC_WR = 2'd1;
  localparam logic [1:0] ACC_RW = 2'd2;

  typedef struct packed {
    logic [PADDR_W-1:0]  paddr;
    logic [BUFLEN_W-1:0] buflen;
    logic [1:0]          accesdesc;
    logic [RKEY_W-1:0]   rkey;
  } dma_req_t;

  // 104-bit datamover command; tag is zero-extended to a byte
  typedef struct packed {
    logic [7:0]         tag;
    logic [PADDR_W-1:0] addr;
    logic               drr;
    logic               eof;
    logic [5:0]         dsa;
    logic               incr;
    logic [BTT_W-1:0]   btt;
  } dm_cmd_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_ACCESS = 2'd1,
    ERR_BOUNDS = 2'd2,
    ERR_MISS   = 2'd3
  } err_code_e;

endpackage

// File: rtl/roce_stack_cmd_splitter.sv
// Splits one segment into datamover commands of at most 2^CHUNK_LOG2 bytes with a rolling tag.
module roce_stack_cmd_splitter
  import roce_stack_pkg::*;
#(
  parameter int unsigned LEN_W      = 32,
  parameter int unsigned CHUNK_LOG2 = 22,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                 clk_i,
  input  logic                 aresetn_i,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic [PADDR_W-1:0]   paddr_i,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output dm_cmd_t              cmd_data_o,
  output logic                 done_o
);

  localparam logic [LEN_W-1:0] CHUNK = LEN_W'(64'd1 << CHUNK_LOG2);

  logic [LEN_W-1:0]   remaining;
  logic [PADDR_W-1:0] paddr;
  logic [TAG_W-1:0]   tag;
  logic [LEN_W-1:0]   btt_c;
  logic [LEN_W-1:0]   rem_next_c;
  logic [PADDR_W-1:0] paddr_next_c;
  logic [TAG_W-1:0]   tag_next_c;

  function automatic dm_cmd_t mk_cmd(input logic [LEN_W-1:0] rem, input logic [PADDR_W-1:0] addr,
                                     input logic [TAG_W-1:0] t);
    dm_cmd_t c;
    c      = '0;
    c.tag  = 8'(t);
    c.addr = addr;
    c.eof  = (rem <= CHUNK);
    c.incr = 1'b1;
    c.btt  = (rem > CHUNK) ? BTT_W'(CHUNK) : BTT_W'(rem);
    return c;
  endfunction

  assign btt_c        = (remaining > CHUNK) ? CHUNK : remaining;
  assign rem_next_c   = remaining - btt_c;
  assign paddr_next_c = paddr + PADDR_W'(btt_c);
  assign tag_next_c   = tag + TAG_W'(1);

  // Next chunk is presented the cycle after a handshake, valid stays high between chunks
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      remaining   <= '0;
      paddr       <= '0;
      tag         <= '0;
      cmd_valid_o <= 1'b0;
      cmd_data_o  <= '0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        remaining   <= len_i;
        paddr       <= paddr_i;
        cmd_valid_o <= 1'b1;
        cmd_data_o  <= mk_cmd(len_i, paddr_i, tag);
      end else if (cmd_valid_o && cmd_ready_i) begin
        remaining <= rem_next_c;
        paddr     <= paddr_next_c;
        tag       <= tag_next_c;
        if (rem_next_c == '0) begin
          cmd_valid_o <= 1'b0;
          done_o      <= 1'b1;
        end else begin
          cmd_data_o <= mk_cmd(rem_next_c, paddr_next_c, tag_next_c);
        end
      end
    end
  end

endmodule

// File: rtl/roce_stack_req_handler_split.sv
// RoCE segment request handler: per-message address translation, bounds/access checks,
// chunked datamover command issue, error reporting and write-path buffer writeback.
module roce_stack_req_handler_split
  import roce_stack_pkg::*;
#(
  parameter logic        READ       = 1'b1,
  parameter int unsigned LEN_W      = 32,
  parameter int unsigned CHUNK_LOG2 = 22,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                clk_i,
  input  logic                aresetn_i,
  input  logic                s_rdma_req_valid_i,
  output logic                s_rdma_req_ready_o,
  input  logic [63:0]         s_rdma_req_vaddr_i,
  input  logic [LEN_W-1:0]    s_rdma_req_len_i,
  input  logic [15:0]         s_rdma_req_qpn_i,
  input  logic                s_rdma_req_last_i,
  output logic                req_addr_valid_o,
  input  logic                req_addr_ready_i,
  output logic [63:0]         req_addr_vaddr_o,
  output logic [15:0]         req_addr_qpn_o,
  input  logic                resp_addr_valid_i,
  output logic                resp_addr_ready_o,
  input  dma_req_t            resp_addr_data_i,
  output logic                cmd_valid_o,
  input  logic                cmd_ready_i,
  output dm_cmd_t             cmd_data_o,
  output logic                err_valid_o,
  output logic [1:0]          err_code_o,
  output logic                err_st_o,
  output logic                wb_valid_o,
  output logic [71:0]         wb_rqbufaddr_o,
  output logic [39:0]         wb_rqpidb_o
);

  typedef enum logic [2:0] {S_IDLE, S_XREQ, S_XRESP, S_CHECK, S_ISSUE, S_DONE, S_WB} state_e;

  state_e              state;
  logic [LEN_W-1:0]    seg_len;
  logic                seg_last;
  logic [LEN_W-1:0]    total_len;
  logic                total_ovf;
  logic                first;
  logic [PADDR_W-1:0]  paddr;
  logic [PADDR_W-1:0]  paddr_base;
  logic [BUFLEN_W-1:0] buflen;
  logic [1:0]          acc;
  logic [RKEY_W-1:0]   rkey;
  logic                split_start;
  logic                split_done;

  logic [LEN_W:0]      total_sum_c;
  logic                access_ok_c;
  logic [1:0]          chk_code_c;
  logic                seg_err_c;
  logic [1:0]          seg_code_c;

  assign total_sum_c = {1'b0, total_len} + {1'b0, s_rdma_req_len_i};
  assign access_ok_c = (acc == ACC_RW) || (READ ? (acc == ACC_RD) : (acc == ACC_WR));

  // Priority: translation miss, then access, then bounds
  always_comb begin
    chk_code_c = ERR_NONE;
    if (buflen == '0)
      chk_code_c = ERR_MISS;
    else if (!access_ok_c)
      chk_code_c = ERR_ACCESS;
    else if (total_ovf || (64'(total_len) > 64'(buflen)))
      chk_code_c = ERR_BOUNDS;
  end

  // A message already in error keeps failing with its latched code
  assign seg_err_c  = (chk_code_c != ERR_NONE) || err_st_o;
  assign seg_code_c = (chk_code_c != ERR_NONE) ? chk_code_c : err_code_o;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state              <= S_IDLE;
      s_rdma_req_ready_o <= 1'b0;
      req_addr_valid_o   <= 1'b0;
      req_addr_vaddr_o   <= '0;
      req_addr_qpn_o     <= '0;
      resp_addr_ready_o  <= 1'b0;
      err_valid_o        <= 1'b0;
      err_code_o         <= '0;
      err_st_o           <= 1'b0;
      wb_valid_o         <= 1'b0;
      wb_rqbufaddr_o     <= '0;
      wb_rqpidb_o        <= '0;
      seg_len            <= '0;
      seg_last           <= 1'b0;
      total_len          <= '0;
      total_ovf          <= 1'b0;
      first              <= 1'b1;
      paddr              <= '0;
      paddr_base         <= '0;
      buflen             <= '0;
      acc                <= '0;
      rkey               <= '0;
      split_start        <= 1'b0;
    end else begin
      err_valid_o <= 1'b0;
      wb_valid_o  <= 1'b0;
      split_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (s_rdma_req_ready_o && s_rdma_req_valid_i) begin
            s_rdma_req_ready_o <= 1'b0;
            seg_len            <= s_rdma_req_len_i;
            seg_last           <= s_rdma_req_last_i;
            if (total_sum_c[LEN_W]) begin
              total_len <= '1;
              total_ovf <= 1'b1;
            end else begin
              total_len <= total_sum_c[LEN_W-1:0];
            end
            if (first) begin
              first            <= 1'b0;
              req_addr_vaddr_o <= s_rdma_req_vaddr_i;
              req_addr_qpn_o   <= s_rdma_req_qpn_i;
              req_addr_valid_o <= 1'b1;
              state            <= S_XREQ;
            end else begin
              state <= S_CHECK;
            end
          end else begin
            s_rdma_req_ready_o <= 1'b1;
          end
        end
        S_XREQ: begin
          if (req_addr_ready_i) begin
            req_addr_valid_o  <= 1'b0;
            resp_addr_ready_o <= 1'b1;
            state             <= S_XRESP;
          end
        end
        S_XRESP: begin
          if (resp_addr_valid_i) begin
            resp_addr_ready_o <= 1'b0;
            paddr             <= resp_addr_data_i.paddr;
            paddr_base        <= resp_addr_data_i.paddr;
            buflen            <= resp_addr_data_i.buflen;
            acc               <= resp_addr_data_i.accesdesc;
            rkey              <= resp_addr_data_i.rkey;
            state             <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (seg_err_c) begin
            err_valid_o <= 1'b1;
            err_st_o    <= 1'b1;
            err_code_o  <= seg_code_c;
            state       <= S_DONE;
          end else if (seg_len == '0) begin
            state <= S_DONE;
          end else begin
            split_start <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (split_done) state <= S_DONE;
        end
        S_DONE: begin
          // Skipped segments still consume their share of the buffer
          paddr <= paddr + PADDR_W'(seg_len);
          if (seg_last) begin
            total_len <= '0;
            total_ovf <= 1'b0;
            first     <= 1'b1;
            if (!READ && (req_addr_vaddr_o == '0) && !err_st_o) begin
              wb_valid_o     <= 1'b1;
              wb_rqbufaddr_o <= {req_addr_qpn_o, 56'(paddr_base + PADDR_W'(buflen))};
              wb_rqpidb_o    <= {req_addr_qpn_o, rkey + RKEY_W'(1)};
              state          <= S_WB;
            end else begin
              err_st_o           <= 1'b0;
              err_code_o         <= '0;
              s_rdma_req_ready_o <= 1'b1;
              state              <= S_IDLE;
            end
          end else begin
            s_rdma_req_ready_o <= 1'b1;
            state              <= S_IDLE;
          end
        end
        S_WB: begin
          s_rdma_req_ready_o <= 1'b1;
          state              <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  roce_stack_cmd_splitter #(
    .LEN_W      (LEN_W),
    .CHUNK_LOG2 (CHUNK_LOG2),
    .TAG_W      (TAG_W)
  ) u_splitter (
    .clk_i       (clk_i),
    .aresetn_i   (aresetn_i),
    .start_i     (split_start),
    .len_i       (seg_len),
    .paddr_i     (paddr),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_data_o  (cmd_data_o),
    .done_o      (split_done)
  );

endmodule

// File: tb/tb_roce_stack_req_handler_split.sv
// Bench for roce_stack_req_handler_split (write path): directed cases plus random messages
// checked against a transaction-level reference model.
module tb_roce_stack_req_handler_split;

  localparam longint unsigned CHUNK = 64'd1 << 22;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [63:0]   req_vaddr;
  logic [31:0]   req_len;
  logic [15:0]   req_qpn;
  logic          req_last;
  logic          xreq_valid;
  logic          xreq_ready;
  logic [63:0]   xreq_vaddr;
  logic [15:0]   xreq_qpn;
  logic          xresp_valid;
  logic          xresp_ready;
  logic [121:0]  xresp_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [103:0]  cmd_data;
  logic          err_valid;
  logic [1:0]    err_code;
  logic          err_st;
  logic          wb_valid;
  logic [71:0]   wb_rqbufaddr;
  logic [39:0]   wb_rqpidb;

  always #5 clk = ~clk;

  roce_stack_req_handler_split #(
    .READ(1'b0), .LEN_W(32), .CHUNK_LOG2(22), .TAG_W(4)
  ) dut (
    .clk_i(clk), .aresetn_i(rst_n),
    .s_rdma_req_valid_i(req_valid), .s_rdma_req_ready_o(req_ready),
    .s_rdma_req_vaddr_i(req_vaddr), .s_rdma_req_len_i(req_len),
    .s_rdma_req_qpn_i(req_qpn), .s_rdma_req_last_i(req_last),
    .req_addr_valid_o(xreq_valid), .req_addr_ready_i(xreq_ready),
    .req_addr_vaddr_o(xreq_vaddr), .req_addr_qpn_o(xreq_qpn),
    .resp_addr_valid_i(xresp_valid), .resp_addr_ready_o(xresp_ready),
    .resp_addr_data_i(xresp_data),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_data_o(cmd_data),
    .err_valid_o(err_valid), .err_code_o(err_code), .err_st_o(err_st),
    .wb_valid_o(wb_valid), .wb_rqbufaddr_o(wb_rqbufaddr), .wb_rqpidb_o(wb_rqpidb)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Observed and expected transaction streams
  logic [103:0] got_cmd[$];
  logic [103:0] exp_cmd[$];
  logic [1:0]   got_err[$];
  logic [1:0]   exp_err[$];
  logic [111:0] got_wb[$];
  logic [111:0] exp_wb[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) got_cmd.push_back(cmd_data);
      if (err_valid) got_err.push_back(err_code);
      if (wb_valid) got_wb.push_back({wb_rqbufaddr, wb_rqpidb});
    end
  end

  // 0: random backpressure, 1: always stalled, 2: always ready
  int rdy_mode = 0;
  initial begin
    cmd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       cmd_ready = 1'b0;
        2:       cmd_ready = 1'b1;
        default: cmd_ready = ($urandom % 4) != 0;
      endcase
    end
  end

  function automatic logic [103:0] mk_cmd(input int tag, input logic [63:0] addr, input bit eof,
                                          input longint unsigned btt);
    logic [3:0]  t4;
    logic [22:0] b;
    t4 = 4'(tag);
    b  = 23'(btt);
    return {4'b0, t4, addr, 1'b0, eof, 6'b0, 1'b1, b};
  endfunction

  // Reference model: message context and its rules
  bit              m_first = 1'b1;
  logic [63:0]     m_base;
  logic [31:0]     m_buflen;
  logic [1:0]      m_acc;
  logic [23:0]     m_rkey;
  logic [15:0]     m_qpn;
  logic [63:0]     m_vaddr;
  longint unsigned m_off;
  longint unsigned m_total = 0;
  bit              m_err = 1'b0;
  logic [1:0]      m_code = 2'd0;
  int              m_tag = 0;
  bit              exp_st;

  task automatic model_seg(input longint unsigned len, input bit last);
    logic [1:0] code;
    longint unsigned off;
    longint unsigned b;
    m_total += len;
    if (m_buflen == 0) code = 2'd3;
    else if (!(m_acc == 2'd1 || m_acc == 2'd2)) code = 2'd1;
    else if (m_total > longint'(m_buflen)) code = 2'd2;
    else code = 2'd0;
    if (code == 2'd0 && m_err) code = m_code;
    if (code != 2'd0) begin
      exp_err.push_back(code);
      m_err  = 1'b1;
      m_code = code;
    end else begin
      off = 0;
      while (off < len) begin
        b = (len - off > CHUNK) ? CHUNK : len - off;
        exp_cmd.push_back(mk_cmd(m_tag, m_base + 64'(m_off + off), (off + b == len), b));
        m_tag = (m_tag + 1) % 16;
        off += b;
      end
    end
    m_off += len;
    if (last) begin
      if (m_vaddr == 0 && !m_err)
        exp_wb.push_back({m_qpn, 56'(m_base + 64'(m_buflen)), m_qpn, 24'(m_rkey + 24'd1)});
      m_first = 1'b1;
      m_err   = 1'b0;
      m_total = 0;
      exp_st  = 1'b0;
    end else begin
      exp_st = m_err;
    end
  endtask

  task automatic compare_streams();
    check("n_cmd", 128'(got_cmd.size()), 128'(exp_cmd.size()));
    for (int i = 0; i < exp_cmd.size(); i++)
      if (i < got_cmd.size()) check("cmd", 128'(got_cmd[i]), 128'(exp_cmd[i]));
    check("n_err", 128'(got_err.size()), 128'(exp_err.size()));
    for (int i = 0; i < exp_err.size(); i++)
      if (i < got_err.size()) check("err_code", 128'(got_err[i]), 128'(exp_err[i]));
    check("n_wb", 128'(got_wb.size()), 128'(exp_wb.size()));
    for (int i = 0; i < exp_wb.size(); i++)
      if (i < got_wb.size()) check("wb", 128'(got_wb[i]), 128'(exp_wb[i]));
    check("err_st", 128'(err_st), 128'(exp_st));
    got_cmd.delete(); exp_cmd.delete();
    got_err.delete(); exp_err.delete();
    got_wb.delete();  exp_wb.delete();
  endtask

  // Drive one segment; the translation fields apply only on the first segment of a message
  task automatic send_seg(input logic [63:0] va, input longint unsigned len, input logic [15:0] qpn,
                          input bit last, input logic [63:0] pa, input logic [31:0] bl,
                          input logic [1:0] acc, input logic [23:0] rk, input bit abort);
    bit was_first;
    int cnt;
    was_first = m_first;
    if (m_first) begin
      m_base = pa; m_buflen = bl; m_acc = acc; m_rkey = rk;
      m_qpn = qpn; m_vaddr = va; m_off = 0; m_first = 1'b0;
    end
    if (!abort) model_seg(len, last);
    @(posedge clk); #1;
    req_valid = 1'b1; req_vaddr = va; req_len = 32'(len); req_qpn = qpn; req_last = last;
    cnt = 0;
    @(negedge clk);
    while (!req_ready && cnt < 200) begin @(negedge clk); cnt++; end
    if (!req_ready) begin check("req_accept_timeout", 128'(0), 128'(1)); req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (was_first) begin
      cnt = 0;
      @(negedge clk);
      while (!xreq_valid && cnt < 50) begin @(negedge clk); cnt++; end
      check("xlate_req_valid", 128'(xreq_valid), 128'(1));
      check("xlate_vaddr", 128'(xreq_vaddr), 128'(va));
      check("xlate_qpn", 128'(xreq_qpn), 128'(qpn));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xreq_ready = 1'b1;
      @(posedge clk); #1;
      xreq_ready = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      xresp_valid = 1'b1;
      xresp_data  = {pa, bl, acc, rk};
      cnt = 0;
      @(negedge clk);
      while (!xresp_ready && cnt < 50) begin @(negedge clk); cnt++; end
      check("xlate_resp_ready", 128'(xresp_ready), 128'(1));
      @(posedge clk); #1;
      xresp_valid = 1'b0;
    end
    if (abort) return;
    cnt = 0;
    @(negedge clk);
    while (!req_ready && cnt < 5000) begin @(negedge clk); cnt++; end
    check("seg_retire", 128'(req_ready), 128'(1));
    compare_streams();
  endtask

  logic [103:0] exp_stall;
  int           nseg;
  logic [63:0]  r_pa;
  logic [63:0]  r_va;
  logic [31:0]  r_bl;
  logic [1:0]   r_acc;
  logic [15:0]  r_qpn;
  longint unsigned r_len;

  initial begin
    #800_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_vaddr = '0; req_len = '0; req_qpn = '0; req_last = 1'b0;
    xreq_ready = 1'b0; xresp_valid = 1'b0; xresp_data = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_cmd_valid", 128'(cmd_valid), 128'(0));
    check("rst_cmd_data", 128'(cmd_data), 128'(0));
    check("rst_err", 128'({err_valid, err_code, err_st}), 128'(0));
    check("rst_wb", 128'({wb_valid, wb_rqbufaddr, wb_rqpidb}), 128'(0));
    check("rst_xlate", 128'({xreq_valid, xresp_ready}), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 128'(req_ready), 128'(1));

    // Single short segment, non-zero vaddr: one command, no writeback
    send_seg(64'h1000, 256, 16'h0011, 1'b1, 64'h8000_0000, 32'd4096, 2'd1, 24'h000100, 1'b0);
    // 10 MiB segment split into 4M/4M/2M
    send_seg(64'h2000, 10 * 2**20, 16'h0022, 1'b1, 64'h1_0000_0000, 32'(16 * 2**20), 2'd2, 24'h5, 1'b0);
    // Three-segment message with vaddr 0: one translation, writeback at the end
    send_seg(64'h0, 100, 16'h0033, 1'b0, 64'h4000, 32'd4096, 2'd1, 24'hABCDEF, 1'b0);
    send_seg(64'h0, 200, 16'h0033, 1'b0, '0, '0, '0, '0, 1'b0);
    send_seg(64'h0, 300, 16'h0033, 1'b1, '0, '0, '0, '0, 1'b0);
    // Access violation on write path, repeated on the next segment
    send_seg(64'h3000, 64, 16'h0044, 1'b0, 64'h9000, 32'd4096, 2'd0, 24'h1, 1'b0);
    send_seg(64'h3000, 64, 16'h0044, 1'b1, '0, '0, '0, '0, 1'b0);
    // Bounds: second segment overruns buffer; vaddr 0 with error gives no writeback
    send_seg(64'h0, 400, 16'h0055, 1'b0, 64'hA000, 32'd512, 2'd1, 24'h7, 1'b0);
    send_seg(64'h0, 200, 16'h0055, 1'b1, '0, '0, '0, '0, 1'b0);
    // Translation miss
    send_seg(64'h0, 32, 16'h0066, 1'b1, 64'hB000, 32'd0, 2'd1, 24'h9, 1'b0);

    // Backpressure: command must hold stable while stalled
    exp_stall = mk_cmd(m_tag, 64'hC000, 1'b1, 300);
    rdy_mode = 1;
    fork
      send_seg(64'h7000, 300, 16'h0077, 1'b1, 64'hC000, 32'd4096, 2'd1, 24'h2, 1'b0);
      begin
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (!cmd_valid && cnt < 100) begin @(negedge clk); cnt++; end
        for (int i = 0; i < 5; i++) begin
          check("stall_valid", 128'(cmd_valid), 128'(1));
          check("stall_data", 128'(cmd_data), 128'(exp_stall));
          @(negedge clk);
        end
        rdy_mode = 2;
      end
    join

    // Running length overflow forces a bounds error even with a maximal buffer
    send_seg(64'h5000, 64'hF000_0000, 16'h0088, 1'b0, 64'h2_0000_0000, 32'hFFFF_FFFF, 2'd2, 24'h3, 1'b0);
    send_seg(64'h5000, 64'h2000_0000, 16'h0088, 1'b1, '0, '0, '0, '0, 1'b0);
    rdy_mode = 0;

    // Random messages
    for (int m = 0; m < 25; m++) begin
      nseg  = $urandom_range(1, 4);
      r_pa  = {$urandom, $urandom};
      r_va  = ($urandom % 3 == 0) ? 64'h0 : {$urandom, $urandom};
      r_qpn = 16'($urandom);
      r_acc = ($urandom % 4 == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
      case ($urandom % 8)
        0:       r_bl = 32'd0;
        1, 2:    r_bl = 32'($urandom_range(1, 2000));
        default: r_bl = 32'($urandom_range(1000, 20_000_000));
      endcase
      for (int s = 0; s < nseg; s++) begin
        r_len = ($urandom % 4 == 0) ? longint'($urandom_range(1, 12_000_000))
                                    : longint'($urandom_range(1, 1500));
        send_seg(r_va, r_len, r_qpn, (s == nseg - 1), r_pa, r_bl, r_acc, 24'($urandom), 1'b0);
      end
    end

    // Asynchronous reset while a command is pending
    rdy_mode = 1;
    send_seg(64'h6000, 1000, 16'h0099, 1'b1, 64'hD000, 32'd4096, 2'd1, 24'h4, 1'b1);
    begin
      int cnt;
      cnt = 0;
      @(negedge clk);
      while (!cmd_valid && cnt < 100) begin @(negedge clk); cnt++; end
      check("abort_cmd_pending", 128'(cmd_valid), 128'(1));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_cmd_valid", 128'(cmd_valid), 128'(0));
    check("abort_cmd_data", 128'(cmd_data), 128'(0));
    check("abort_handshakes", 128'({req_ready, xreq_valid, xresp_ready, err_valid, wb_valid}), 128'(0));
    m_first = 1'b1; m_tag = 0; m_err = 1'b0; m_total = 0;
    got_cmd.delete(); exp_cmd.delete(); got_err.delete(); exp_err.delete();
    got_wb.delete(); exp_wb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    // Tag restarts from zero after reset
    send_seg(64'h1000, 256, 16'h00AA, 1'b1, 64'hE000, 32'd4096, 2'd1, 24'h6, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
